// File: rtl/router_pkt_tx_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Header layout is {len[5:0], addr[1:0]}.
package router_pkt_tx_pkg;

  localparam int HDR_LEN_W  = 6;
  localparam int HDR_ADDR_W = 2;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_DONE
  } state_e;

  function automatic logic [DATA_W-1:0] hdr_pack(
    input logic [HDR_LEN_W-1:0]  len,
    input logic [HDR_ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload byte buffer: sequential write pointer, random read index,
// occupancy count and full flag.
module router_tx_buf
  import router_pkt_tx_pkg::*;
#(
  parameter int DEPTH = 63
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 wr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic                 clr_i,
  input  logic [HDR_LEN_W-1:0] rd_idx_i,
  output logic [DATA_W-1:0]    rd_data_o,
  output logic [HDR_LEN_W-1:0] count_o,
  output logic                 full_o
);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [HDR_LEN_W-1:0] count_q;
  logic                 wr_ok;

  assign full_o    = (count_q == HDR_LEN_W'(DEPTH));
  assign wr_ok     = wr_i && !full_o;
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_idx_i];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (wr_ok) begin
      count_q <= count_q + HDR_LEN_W'(1);
    end
  end

  // Storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem_q[count_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: header, payload and parity
// framed with pkt_valid, stalling on rtr_busy.
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int DEPTH = 63
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pay_wr,
  input  logic [DATA_W-1:0]     pay_wdata,
  input  logic                  start,
  input  logic [HDR_ADDR_W-1:0] dest_addr,
  input  logic                  inject_err,
  input  logic                  rtr_busy,
  output logic [DATA_W-1:0]     data_out,
  output logic                  pkt_valid,
  output logic                  tx_active,
  output logic [HDR_LEN_W-1:0]  buf_count,
  output logic                  buf_full,
  output logic                  done
);

  state_e               state_q;
  logic [HDR_LEN_W-1:0] len_q;
  logic [HDR_LEN_W-1:0] idx_q;
  logic                 err_q;
  logic [DATA_W-1:0]    par_q;
  logic [DATA_W-1:0]    dout_q;
  logic                 pv_q;
  logic                 act_q;
  logic                 done_q;

  logic                 buf_wr;
  logic                 buf_clr;
  logic [HDR_LEN_W-1:0] rd_idx;
  logic [DATA_W-1:0]    rd_data;
  logic [DATA_W-1:0]    par_d;
  logic [DATA_W-1:0]    hdr_d;

  assign buf_wr  = pay_wr && !start && (state_q == S_IDLE);
  assign buf_clr = (state_q == S_PARITY) && !rtr_busy;
  // Prefetch the byte that follows the one currently on data_out.
  assign rd_idx  = (state_q == S_HEADER) ? '0 : idx_q + HDR_LEN_W'(1);
  assign par_d   = par_q ^ dout_q;
  assign hdr_d   = hdr_pack(buf_count, dest_addr);

  router_tx_buf #(.DEPTH(DEPTH)) u_buf (
    .clock     (clock),
    .resetn    (resetn),
    .wr_i      (buf_wr),
    .wdata_i   (pay_wdata),
    .clr_i     (buf_clr),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data),
    .count_o   (buf_count),
    .full_o    (buf_full)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      par_q   <= '0;
      dout_q  <= '0;
      pv_q    <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && buf_count != '0) begin
            state_q <= S_HEADER;
            len_q   <= buf_count;
            err_q   <= inject_err;
            dout_q  <= hdr_d;
            par_q   <= hdr_d;
            pv_q    <= 1'b1;
            act_q   <= 1'b1;
          end
        end
        S_HEADER: begin
          if (!rtr_busy) begin
            state_q <= S_PAYLOAD;
            idx_q   <= '0;
            dout_q  <= rd_data;
          end
        end
        S_PAYLOAD: begin
          if (!rtr_busy) begin
            par_q <= par_d;
            if (idx_q == len_q - HDR_LEN_W'(1)) begin
              state_q <= S_PARITY;
              dout_q  <= err_q ? ~par_d : par_d;
              pv_q    <= 1'b0;
            end else begin
              idx_q  <= idx_q + HDR_LEN_W'(1);
              dout_q <= rd_data;
            end
          end
        end
        S_PARITY: begin
          if (!rtr_busy) begin
            state_q <= S_DONE;
            dout_q  <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out  = dout_q;
  assign pkt_valid = pv_q;
  assign tx_active = act_q;
  assign done      = done_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed vectors, stall/limit/reset
// sequences and random packets against a queue-based model.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pay_wr;
  logic [7:0] pay_wdata;
  logic       start;
  logic [1:0] dest_addr;
  logic       inject_err;
  logic       rtr_busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic [5:0] buf_count;
  logic       buf_full;
  logic       done;

  always #5 clock = ~clock;

  router_pkt_tx #(.DEPTH(63)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pay_wr     (pay_wr),
    .pay_wdata  (pay_wdata),
    .start      (start),
    .dest_addr  (dest_addr),
    .inject_err (inject_err),
    .rtr_busy   (rtr_busy),
    .data_out   (data_out),
    .pkt_valid  (pkt_valid),
    .tx_active  (tx_active),
    .buf_count  (buf_count),
    .buf_full   (buf_full),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mbuf [$];

  typedef struct {
    int         n;
    logic [7:0] b [4];
    logic [1:0] addr;
    bit         err;
    logic [7:0] hdr;
    logic [7:0] par;
  } vec_t;

  vec_t tv [4];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    pay_wr    = 1'b1;
    pay_wdata = b;
    tick();
    pay_wr = 1'b0;
    if (mbuf.size() < 63) mbuf.push_back(b);
  endtask

  // mode 0: no stall, 1: random stall, 2: sn stall cycles at stream pos spos
  task automatic run_pkt(input logic [1:0] addr, input bit err,
                         input int mode, input int spos, input int sn,
                         output logic [7:0] hdr_seen,
                         output logic [7:0] par_seen);
    logic [7:0] stream [$];
    logic [7:0] p;
    int len, pos, cyc, stalls, left;
    bit b;
    len = mbuf.size();
    p = 8'((len * 4) + addr);
    stream.push_back(p);
    foreach (mbuf[i]) begin
      stream.push_back(mbuf[i]);
      p = p ^ mbuf[i];
    end
    stream.push_back(err ? ~p : p);
    hdr_seen = 8'h00;
    par_seen = 8'h00;
    start = 1'b1; dest_addr = addr; inject_err = err;
    pay_wr = 1'b1; pay_wdata = 8'($urandom);
    tick();
    start = 1'b0; pay_wr = 1'b0;
    dest_addr = 2'($urandom); inject_err = 1'($urandom);
    pos = 0; cyc = 0; stalls = 0; left = sn;
    while (pos < len + 2 && cyc < 1000) begin
      chk("data_out", data_out, stream[pos]);
      chk("pkt_valid", pkt_valid, pos <= len);
      chk("tx_active", tx_active, 1);
      if (pos == 0) hdr_seen = data_out;
      if (pos == len + 1) par_seen = data_out;
      b = 1'b0;
      if (mode == 1) b = ($urandom_range(0, 3) == 0);
      if (mode == 2 && pos == spos && left > 0) begin
        b = 1'b1;
        left--;
      end
      if (b) stalls++;
      rtr_busy = b;
      pay_wr = 1'($urandom);
      pay_wdata = 8'($urandom);
      start = 1'($urandom);
      tick();
      if (!b) pos++;
      cyc++;
    end
    rtr_busy = 1'b0; pay_wr = 1'b0; start = 1'b0;
    chk("pkt_cycles", cyc, len + 2 + stalls);
    chk("done", done, 1);
    chk("count_at_done", buf_count, 0);
    chk("tx_active_at_done", tx_active, 0);
    chk("pkt_valid_at_done", pkt_valid, 0);
    mbuf.delete();
    tick();
    chk("done_pulse", done, 0);
  endtask

  task automatic set_vec(input int i, input int n, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input logic [1:0] a, input bit e,
                         input logic [7:0] h, input logic [7:0] pr);
    tv[i].n = n;
    tv[i].b[0] = b0; tv[i].b[1] = b1; tv[i].b[2] = b2; tv[i].b[3] = 8'h00;
    tv[i].addr = a; tv[i].err = e; tv[i].hdr = h; tv[i].par = pr;
  endtask

  initial begin
    logic [7:0] hs, ps;
    int n;
    resetn = 1'b0; pay_wr = 1'b0; pay_wdata = 8'h00; start = 1'b0;
    dest_addr = 2'd0; inject_err = 1'b0; rtr_busy = 1'b0;
    tick(); tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_done", done, 0);
    resetn = 1'b1;
    tick();

    set_vec(0, 3, 8'hA1, 8'h5B, 8'h3C, 2'd1, 1'b0, 8'h0D, 8'hCB);
    set_vec(1, 3, 8'hA1, 8'h5B, 8'h3C, 2'd1, 1'b1, 8'h0D, 8'h34);
    set_vec(2, 1, 8'hFF, 8'h00, 8'h00, 2'd3, 1'b0, 8'h07, 8'hF8);
    set_vec(3, 2, 8'h00, 8'h00, 8'h00, 2'd2, 1'b0, 8'h0A, 8'h0A);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < tv[i].n; j++) wr(tv[i].b[j]);
      chk("vec_count", buf_count, tv[i].n);
      run_pkt(tv[i].addr, tv[i].err, 0, 0, 0, hs, ps);
      chk("vec_hdr", hs, tv[i].hdr);
      chk("vec_par", ps, tv[i].par);
    end

    wr(8'hA1); wr(8'h5B); wr(8'h3C);
    run_pkt(2'd1, 1'b0, 2, 2, 3, hs, ps);
    chk("stall_par", ps, 8'hCB);

    for (int i = 0; i < 64; i++) wr(8'($urandom));
    chk("full_flag", buf_full, 1);
    chk("full_count", buf_count, 63);
    run_pkt(2'd0, 1'b0, 1, 0, 0, hs, ps);
    chk("full_hdr", hs, 8'hFC);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start_valid", pkt_valid, 0);
    chk("empty_start_active", tx_active, 0);
    tick();
    chk("empty_start_valid2", pkt_valid, 0);
    chk("empty_start_count", buf_count, 0);

    for (int i = 0; i < 5; i++) wr(8'($urandom));
    start = 1'b1; dest_addr = 2'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_in_payload", pkt_valid, 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    mbuf.delete();
    chk("mid_data_out", data_out, 0);
    chk("mid_pkt_valid", pkt_valid, 0);
    chk("mid_tx_active", tx_active, 0);
    chk("mid_buf_count", buf_count, 0);
    chk("mid_buf_full", buf_full, 0);
    chk("mid_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("post_rst_start_active", tx_active, 0);
    chk("post_rst_start_valid", pkt_valid, 0);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 63);
      for (int i = 0; i < n; i++) wr(8'($urandom));
      run_pkt(2'($urandom), 1'($urandom), 1, 0, 0, hs, ps);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
